// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states and
// instruction field positions.
package cpu_ctrl_pkg;

    // Opcode values match the ALU's own encoding.
    localparam logic [2:0] AND_OP   = 3'b000;
    localparam logic [2:0] ADD_OP   = 3'b001;
    localparam logic [2:0] XOR_OP   = 3'b010;
    localparam logic [2:0] LOAD_OP  = 3'b011;
    localparam logic [2:0] STORE_OP = 3'b100;
    localparam logic [2:0] JMP_OP   = 3'b101;
    localparam logic [2:0] SUB_OP   = 3'b110;
    localparam logic [2:0] SHF_OP   = 3'b111;

    // Instruction layout: [8:6] opcode, [5:4] rd, [3:0] imm, [1:0] rs.
    localparam int INSTR_W = 9;
    localparam int OP_HI   = 8;
    localparam int OP_LO   = 6;
    localparam int RD_HI   = 5;
    localparam int RD_LO   = 4;
    localparam int IMM_HI  = 3;
    localparam int IMM_LO  = 0;
    localparam int RS_HI   = 1;
    localparam int RS_LO   = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    // Opcodes that compute in the ALU and write back its result.
    function automatic logic is_alu_op(input logic [2:0] op);
        case (op)
            AND_OP, ADD_OP, XOR_OP, SUB_OP, SHF_OP: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bus between the sequencer and its environment: start/done, instruction
// memory, register file, ALU and data memory controls.
interface alu_sequencer_if
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    logic               start;
    logic               done;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;
    logic [1:0]         rf_ra;
    logic [1:0]         rf_rb;
    logic [1:0]         rf_wa;
    logic               rf_we;
    logic               rf_wsel;
    logic [2:0]         alu_opcode;
    logic [3:0]         alu_imm;
    logic               alu_zero;
    logic               dmem_req;
    logic               dmem_we;
    logic               dmem_ack;
    logic [CNT_W-1:0]   retired;

    // Sequencer side.
    modport master (
        input  start, imem_ack, imem_data, alu_zero, dmem_ack,
        output done, imem_req, imem_addr, rf_ra, rf_rb, rf_wa, rf_we, rf_wsel,
               alu_opcode, alu_imm, dmem_req, dmem_we, retired
    );

    // Datapath / memory side.
    modport slave (
        output start, imem_ack, imem_data, alu_zero, dmem_ack,
        input  done, imem_req, imem_addr, rf_ra, rf_rb, rf_wa, rf_we, rf_wsel,
               alu_opcode, alu_imm, dmem_req, dmem_we, retired
    );

endinterface

// File: rtl/alu_seq_pc.sv
// Program counter: clear, increment or relative branch by a sign-extended
// 4-bit offset, all wrapping modulo 2^PC_W.
module alu_seq_pc #(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            inc,
    input  logic            br,
    input  logic [3:0]      imm,
    output logic [PC_W-1:0] pc
);
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] offset;

    assign offset = {{(PC_W-4){imm[3]}}, imm};
    assign pc     = pc_q;

    // Clear has priority; branch and increment are mutually exclusive by design.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else if (clr) begin
            pc_q <= '0;
        end else if (br) begin
            pc_q <= pc_q + offset;
        end else if (inc) begin
            pc_q <= pc_q + PC_W'(1);
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 8-opcode ALU datapath.
// Owns IR, zero flag, retire counter and the FSM; the PC lives in alu_seq_pc.
module alu_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_sequencer_if.master bus
);
    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q;
    logic               zflag_q;
    logic [CNT_W-1:0]   retired_q;
    logic               imem_req_q, dmem_req_q, dmem_we_q;
    logic               rf_we_q, rf_wsel_q, done_q;

    logic               launch;     // start accepted: clear PC/flags/counter
    logic               pc_inc;
    logic               pc_br;
    logic               retire;
    logic [PC_W-1:0]    pc;
    logic [2:0]         op;
    logic [3:0]         imm;

    assign op  = ir_q[OP_HI:OP_LO];
    assign imm = ir_q[IMM_HI:IMM_LO];

    alu_seq_pc #(.PC_W(PC_W)) u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (launch),
        .inc   (pc_inc),
        .br    (pc_br),
        .imm   (imm),
        .pc    (pc)
    );

    // Operand selects come straight from IR, which is stable from DECODE to WB.
    assign bus.imem_addr  = pc;
    assign bus.rf_ra      = ir_q[RD_HI:RD_LO];
    assign bus.rf_wa      = ir_q[RD_HI:RD_LO];
    assign bus.rf_rb      = ir_q[RS_HI:RS_LO];
    assign bus.alu_opcode = op;
    assign bus.alu_imm    = imm;
    assign bus.imem_req   = imem_req_q;
    assign bus.dmem_req   = dmem_req_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_wsel    = rf_wsel_q;
    assign bus.done       = done_q;
    assign bus.retired    = retired_q;

    // Next-state and PC/retire control decode.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        pc_inc  = 1'b0;
        pc_br   = 1'b0;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (bus.start) begin
                    state_d = ST_FETCH;
                    launch  = 1'b1;
                end
            end
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_alu_op(op)) begin
                    state_d = ST_WB;
                end else if (op == LOAD_OP || op == STORE_OP) begin
                    state_d = ST_MEM;
                end else begin
                    // JMP: offset 0 is the halt instruction; it still retires.
                    retire = 1'b1;
                    if (imm == 4'd0) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_FETCH;
                        pc_br   = zflag_q;
                        pc_inc  = !zflag_q;
                    end
                end
            end
            ST_MEM: begin
                if (bus.dmem_ack) begin
                    if (op == STORE_OP) begin
                        state_d = ST_FETCH;
                        pc_inc  = 1'b1;
                        retire  = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                pc_inc  = 1'b1;
                retire  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, IR, zero flag, retire counter and strobes registered from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ir_q       <= '0;
            zflag_q    <= 1'b0;
            retired_q  <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_wsel_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_q == ST_FETCH && bus.imem_ack) begin
                ir_q <= bus.imem_data;
            end

            // Only ALU-class instructions update the flag that JMP tests.
            if (launch) begin
                zflag_q <= 1'b0;
            end else if (state_q == ST_EXEC && is_alu_op(op)) begin
                zflag_q <= bus.alu_zero;
            end

            if (launch) begin
                retired_q <= '0;
            end else if (retire && !(&retired_q)) begin
                retired_q <= retired_q + CNT_W'(1);
            end

            imem_req_q <= (state_d == ST_FETCH);
            dmem_req_q <= (state_d == ST_MEM);
            dmem_we_q  <= (state_d == ST_MEM) && (op == STORE_OP);
            rf_we_q    <= (state_d == ST_WB);
            rf_wsel_q  <= (state_d == ST_WB) && (op == LOAD_OP);
            done_q     <= (state_d == ST_HALT);
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: small programs in a 16-word instruction
// memory, a data memory with programmable ack delay, and a SUB-only zero model.
module tb_alu_sequencer;
    localparam int PC_W  = 10;
    localparam int CNT_W = 16;

    localparam logic [8:0] I_ADD_R0_5   = 9'b001_00_0101;
    localparam logic [8:0] I_SUB_R1_R1  = 9'b110_01_0001;
    localparam logic [8:0] I_JMP_P2     = 9'b101_00_0010;
    localparam logic [8:0] I_JMP_P3     = 9'b101_00_0011;
    localparam logic [8:0] I_JMP_M2     = 9'b101_00_1110;
    localparam logic [8:0] I_JMP_HALT   = 9'b101_00_0000;
    localparam logic [8:0] I_LOAD_R2_9  = 9'b011_10_1001;
    localparam logic [8:0] I_STORE_R2_3 = 9'b100_10_0011;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    alu_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [8:0] imem_mem [16];
    logic       imem_en    = 1'b1;
    logic       sub_zero   = 1'b0;
    int         dmem_delay = 0;
    int         dcnt       = 0;
    int         pass_cnt   = 0;
    int         total_cnt  = 0;
    int         cyc        = 0;

    assign bus.imem_ack  = bus.imem_req & imem_en;
    assign bus.imem_data = imem_mem[bus.imem_addr[3:0]];
    assign bus.alu_zero  = sub_zero & (bus.alu_opcode == 3'b110);
    assign bus.dmem_ack  = bus.dmem_req & (dcnt == dmem_delay);

    always @(posedge clk) begin
        if (!bus.dmem_req || bus.dmem_ack) dcnt <= 0;
        else                               dcnt <= dcnt + 1;
    end

    function automatic logic [31:0] outs();
        return {3'b0, bus.done, bus.imem_req, bus.imem_addr, bus.rf_we, bus.rf_wsel,
                bus.dmem_req, bus.dmem_we, bus.rf_ra, bus.rf_rb, bus.rf_wa,
                bus.alu_opcode, bus.alu_imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 16; i++) imem_mem[i] = I_JMP_HALT;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        cyc++;
    endtask

    // Pulse start for one edge; afterwards we sit in cycle 1 (first FETCH).
    task automatic go();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (!bus.done && n < limit) begin
            next_cycle();
            n++;
        end
        chk(tag, 32'(bus.done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] we_hist;
        logic [8:0]  dreq_hist;
        logic        dwe_any;
        logic [3:0]  wb8;
        logic [3:0]  imm5;

        bus.start = 1'b0;
        fill_halt();

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("reset_outputs", outs(), 32'd0);
        chk("reset_retired", 32'(bus.retired), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start", outs(), 32'd0);

        // ---------------- ADD r0,#5; SUB r1,r1; JMP +2 ----------------
        imem_mem[0] = I_ADD_R0_5;
        imem_mem[1] = I_SUB_R1_R1;
        imem_mem[2] = I_JMP_P2;
        imem_mem[3] = I_ADD_R0_5;
        imem_mem[4] = I_JMP_HALT;
        sub_zero    = 1'b1;
        we_hist     = '0;
        go();
        for (int c = 1; c <= 12; c++) begin
            run_to(c);
            we_hist[c-1] = bus.rf_we;
        end
        $display("prog A: rf_we history %03h, pc %0d, retired %0d", we_hist, bus.imem_addr, bus.retired);
        chk("a_rf_we_cycles", 32'(we_hist), 32'h088);
        chk("a_jmp_target", 32'(bus.imem_addr), 32'd4);
        chk("a_retired3", 32'(bus.retired), 32'd3);
        wait_done("a_halt", 10);
        chk("a_halt_cycle", 32'(cyc), 32'd15);
        chk("a_retired4", 32'(bus.retired), 32'd4);
        repeat (5) next_cycle();
        chk("a_done_held", 32'({bus.done, bus.imem_req, bus.dmem_req, bus.rf_we}), 32'b1000);

        // ---------------- restart; JMP -2 at PC 1 wraps ----------------
        fill_halt();
        imem_mem[0] = I_SUB_R1_R1;
        imem_mem[1] = I_JMP_M2;
        go();
        chk("b_restart", 32'({bus.done, bus.imem_req, bus.imem_addr}), 32'h400);
        chk("b_restart_retired", 32'(bus.retired), 32'd0);
        run_to(8);
        $display("prog B: fetch after JMP -2 at pc %0d", bus.imem_addr);
        chk("b_wrap_pc", 32'(bus.imem_addr), 32'd1023);
        wait_done("b_halt", 10);
        chk("b_retired", 32'(bus.retired), 32'd3);

        // ---------------- LOAD r2,#9 with 3-cycle ack delay ----------------
        fill_halt();
        imem_mem[0] = I_LOAD_R2_9;
        sub_zero    = 1'b0;
        dmem_delay  = 3;
        dreq_hist   = '0;
        dwe_any     = 1'b0;
        wb8         = '0;
        imm5        = '0;
        go();
        for (int c = 1; c <= 9; c++) begin
            run_to(c);
            dreq_hist[c-1] = bus.dmem_req;
            dwe_any        = dwe_any | bus.dmem_we;
            if (c == 8) wb8  = {bus.rf_we, bus.rf_wsel, bus.rf_wa};
            if (c == 5) imm5 = bus.alu_imm;
        end
        $display("prog C: dmem_req history %03h, wb %h", dreq_hist, wb8);
        chk("c_dmem_req_cycles", 32'(dreq_hist), 32'h078);
        chk("c_dmem_we_low", 32'(dwe_any), 32'd0);
        chk("c_mem_imm", 32'(imm5), 32'd9);
        chk("c_wb_load", 32'(wb8), 32'hE);
        chk("c_next_fetch", 32'({bus.imem_addr, bus.rf_we}), 32'h002);
        wait_done("c_halt", 10);
        chk("c_retired", 32'(bus.retired), 32'd2);
        dmem_delay = 0;

        // ---------------- SUB zero; STORE; JMP +3 (start during FETCH) ----------------
        fill_halt();
        imem_mem[0] = I_SUB_R1_R1;
        imem_mem[1] = I_STORE_R2_3;
        imem_mem[2] = I_JMP_P3;
        sub_zero    = 1'b1;
        go();
        run_to(8);
        chk("e_store_req", 32'({bus.dmem_req, bus.dmem_we}), 32'b11);
        run_to(9);
        chk("e_after_store", 32'({bus.imem_addr, bus.dmem_req}), 32'h004);
        imem_en   = 1'b0;
        bus.start = 1'b1;
        next_cycle();
        bus.start = 1'b0;
        chk("e_start_ignored", 32'({bus.imem_req, bus.imem_addr}), 32'h402);
        next_cycle();
        chk("e_fetch_stalled", 32'({bus.imem_req, bus.imem_addr}), 32'h402);
        imem_en = 1'b1;
        run_to(14);
        $display("prog E: fetch after JMP +3 at pc %0d, retired %0d", bus.imem_addr, bus.retired);
        chk("e_branch_taken", 32'(bus.imem_addr), 32'd5);
        chk("e_retired3", 32'(bus.retired), 32'd3);
        wait_done("e_halt", 10);
        chk("e_retired4", 32'(bus.retired), 32'd4);

        // ---------------- async reset in the middle of MEM ----------------
        fill_halt();
        imem_mem[0] = I_LOAD_R2_9;
        dmem_delay  = 50;
        go();
        run_to(5);
        chk("r_in_mem", 32'({bus.dmem_req, bus.dmem_we}), 32'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_async_outputs", outs(), 32'd0);
        chk("r_async_retired", 32'(bus.retired), 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        dmem_delay = 0;
        next_cycle();
        chk("r_idle_after", outs(), 32'd0);
        go();
        chk("r_refetch_pc0", 32'({bus.imem_req, bus.imem_addr}), 32'h400);
        wait_done("r_halt", 20);
        chk("r_retired", 32'(bus.retired), 32'd2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
